// File: rtl/ras_ctrl.sv
// ============================================================================
// Module      : ras_ctrl
// Description : Return-address-stack sequencer for the fetch stage. Decodes
//               one accepted instruction per cycle into RAS push/pop/checkpoint
//               commands, splits call+return into pop-then-push, bounds the
//               number of outstanding branch checkpoints and registers the
//               return-target prediction for the next-PC logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_ctrl #(
  parameter int PC_BITS    = 32,
  parameter int CKPT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PC_BITS-1:0] req_pc,
  input  logic               req_is_rvc,
  input  logic               req_is_call,
  input  logic               req_is_ret,
  input  logic               req_is_branch,
  input  logic               resolve_valid,
  input  logic               flush,
  input  logic [PC_BITS-1:0] ras_pc_out,
  input  logic               ras_empty,
  output logic               ras_push,
  output logic               ras_pop,
  output logic [PC_BITS-1:0] ras_new_entry,
  output logic               ras_is_branch,
  output logic               ras_branch_resolved,
  output logic               ras_must_flush,
  output logic               pred_valid,
  output logic               pred_hit,
  output logic [PC_BITS-1:0] pred_target
);

  localparam int             CW          = $clog2(CKPT_DEPTH + 1);
  localparam logic [CW-1:0]  C_CKPT_FULL = CW'(CKPT_DEPTH);
  localparam logic [CW-1:0]  C_CKPT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PUSH = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_ckpt_cnt;
  logic [CW-1:0]      w_ckpt_nxt;
  logic [PC_BITS-1:0] r_ret_addr;
  logic [PC_BITS-1:0] w_ret_addr;
  logic               w_accept;
  logic               w_ckpt_full;

  // Link address of the current instruction; wraps naturally at 2^PC_BITS.
  assign w_ret_addr  = req_pc + (req_is_rvc ? PC_BITS'(2) : PC_BITS'(4));
  assign w_ckpt_full = (r_ckpt_cnt == C_CKPT_FULL);
  assign w_accept    = req_valid & req_ready;

  // Handshake and same-cycle RAS command decode; flush overrides everything.
  always_comb begin
    req_ready           = ~rst & (r_state == S_IDLE) & ~flush
                          & ~(req_is_branch & w_ckpt_full);
    ras_push            = 1'b0;
    ras_pop             = 1'b0;
    ras_new_entry       = '0;
    ras_is_branch       = 1'b0;
    ras_branch_resolved = 1'b0;
    ras_must_flush      = 1'b0;
    if (!rst) begin
      if (flush) begin
        ras_must_flush = 1'b1;
      end else begin
        ras_branch_resolved = resolve_valid & (r_ckpt_cnt != '0);
        if (r_state == S_PUSH) begin
          // Second half of call+return: the pop already issued last cycle.
          ras_push      = 1'b1;
          ras_new_entry = r_ret_addr;
        end else if (w_accept) begin
          if (req_is_call && !req_is_ret) begin
            ras_push      = 1'b1;
            ras_new_entry = w_ret_addr;
          end
          // Popping an empty RAS is never issued; the miss shows in pred_hit.
          if (req_is_ret) begin
            ras_pop = ~ras_empty;
          end
          ras_is_branch = req_is_branch;
        end
      end
    end
  end

  // Next state and checkpoint occupancy; accept already excludes flush.
  always_comb begin
    w_state_nxt = r_state;
    w_ckpt_nxt  = r_ckpt_cnt;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_ckpt_nxt  = '0;
    end else begin
      if (r_state == S_PUSH) begin
        w_state_nxt = S_IDLE;
      end else if (w_accept && req_is_call && req_is_ret) begin
        w_state_nxt = S_PUSH;
      end
      case ({w_accept & req_is_branch, ras_branch_resolved})
        2'b10:   w_ckpt_nxt = r_ckpt_cnt + C_CKPT_ONE;
        2'b01:   w_ckpt_nxt = r_ckpt_cnt - C_CKPT_ONE;
        default: w_ckpt_nxt = r_ckpt_cnt;
      endcase
    end
  end

  // FSM state and checkpoint counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ckpt_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ckpt_cnt <= w_ckpt_nxt;
    end
  end

  // Pending push address and registered return-target prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_addr  <= '0;
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_target <= '0;
    end else begin
      if (w_accept && req_is_call && req_is_ret) begin
        r_ret_addr <= w_ret_addr;
      end
      pred_valid <= w_accept & req_is_ret;
      if (w_accept && req_is_ret) begin
        pred_hit    <= ~ras_empty;
        pred_target <= ras_empty ? '0 : ras_pc_out;
      end
    end
  end

endmodule

`default_nettype wire
